// File: rtl/piano_pkg.sv
// Shared sizing for the key front end, the note mux and the tone bank.
package piano_pkg;
  localparam int NUM_KEYS        = 8;
  localparam int SEL_W           = $clog2(NUM_KEYS);
  localparam int DEBOUNCE_CYCLES = 16;

  typedef enum logic {IDLE, PLAYING} sel_state_t;
endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser followed by a stable-count debouncer.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_db
);
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_db;

  // Bring the asynchronous switch into the clk domain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a change only after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample matching the accepted level restarts the count from zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_key_db <= 1'b0;
    end else if (r_sync2 == r_key_db) begin
      r_cnt    <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_cnt    <= '0;
      r_key_db <= ~r_key_db;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign key_db = r_key_db;
endmodule

// File: rtl/key_select_encoder.sv
// Debounced piano keys -> mux8_1 select with last-pressed priority, plus note gate.
module key_select_encoder #(
  parameter int NUM_KEYS        = piano_pkg::NUM_KEYS,
  parameter int SEL_W           = piano_pkg::SEL_W,
  parameter int DEBOUNCE_CYCLES = piano_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [SEL_W-1:0]    sel,
  output logic                note_on,
  output logic                note_change
);
  import piano_pkg::*;

  logic [NUM_KEYS-1:0] w_key_db;
  logic [NUM_KEYS-1:0] r_key_db_q;
  logic [NUM_KEYS-1:0] w_rise;
  logic [NUM_KEYS-1:0] w_fall;

  sel_state_t          r_state, w_state_nxt;
  logic [SEL_W-1:0]    r_sel, w_sel_nxt;
  logic                r_note_on, w_note_on_nxt;
  logic                r_change, w_change_nxt;

  // Highest set index; ties among simultaneous events resolve upward.
  function automatic logic [SEL_W-1:0] f_hi_idx(input logic [NUM_KEYS-1:0] v);
    f_hi_idx = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (v[k]) f_hi_idx = SEL_W'(k);
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_db (
        .clk    (clk),
        .reset_n(reset_n),
        .key_raw(keys_raw[g]),
        .key_db (w_key_db[g])
      );
    end
  endgenerate

  // One-cycle delayed copy of the debounced keys for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) r_key_db_q <= '0;
    else          r_key_db_q <= w_key_db;
  end

  assign w_rise = w_key_db & ~r_key_db_q;
  assign w_fall = ~w_key_db & r_key_db_q;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_note_on <= 1'b0;
      r_change  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_note_on <= w_note_on_nxt;
      r_change  <= w_change_nxt;
    end
  end

  // Rises always win over falls; a fall only matters when it hits the sounding key.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_note_on_nxt = r_note_on;
    w_change_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_rise) begin
          w_sel_nxt     = f_hi_idx(w_rise);
          w_note_on_nxt = 1'b1;
          w_change_nxt  = 1'b1;
          w_state_nxt   = PLAYING;
        end
      end
      PLAYING: begin
        if (|w_rise) begin
          w_sel_nxt    = f_hi_idx(w_rise);
          w_change_nxt = 1'b1;
        end else if (w_fall[r_sel]) begin
          w_change_nxt = 1'b1;
          if (|w_key_db) begin
            w_sel_nxt = f_hi_idx(w_key_db);
          end else begin
            w_note_on_nxt = 1'b0;
            w_state_nxt   = IDLE;
          end
        end
      end
    endcase
  end

  assign sel         = r_sel;
  assign note_on     = r_note_on;
  assign note_change = r_change;
endmodule

// File: tb/tb_key_select_encoder.sv
`timescale 1ps/1ps
module tb_key_select_encoder;
  localparam int D   = 4;
  localparam int LAT = 2 + D + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] keys_raw = 8'h00;
  logic [2:0] sel;
  logic       note_on;
  logic       note_change;

  typedef struct packed {
    logic [2:0] sel;
    logic       on;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;
  int   p0;

  key_select_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .keys_raw   (keys_raw),
    .sel        (sel),
    .note_on    (note_on),
    .note_change(note_change)
  );

  always #50 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (note_change === 1'b1) begin
        n_pulses++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_pulse: unexpected note_change, sel=%0d note_on=%0b, none expected", sel, note_on);
        end else begin
          mon_e = sb.pop_front();
          if (sel !== mon_e.sel || note_on !== mon_e.on) begin
            n_fail++;
            $display("FAIL sb_pulse: sel=%0d note_on=%0b, expected sel=%0d note_on=%0b", sel, note_on, mon_e.sel, mon_e.on);
          end
        end
      end
    end
  endtask

  task automatic drain(input string name);
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected pulses never seen, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    keys_raw = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_checks++;
      if ({sel, note_on, note_change} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold: sel=%0d note_on=%0b chg=%0b, expected 0/0/0", sel, note_on, note_change);
      end
    end
    reset_n = 1'b1;
    sb.push_back('{sel: 3'd7, on: 1'b1});
    step(LAT - 1);
    n_checks++;
    if (note_on !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_early: note_on=%0b one edge before latency, expected 0", note_on);
    end
    step(1);
    n_checks++;
    if (sel !== 3'd7 || note_on !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_accept: sel=%0d note_on=%0b, expected 7/1", sel, note_on);
    end
    keys_raw = 8'h00;
    sb.push_back('{sel: 3'd7, on: 1'b0});
    step(LAT + 3);
    drain("reset");
  endtask

  task automatic test_single_press();
    keys_raw = 8'h04;
    sb.push_back('{sel: 3'd2, on: 1'b1});
    step(LAT - 1);
    n_checks++;
    if (note_on !== 1'b0 || note_change !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: note_on=%0b chg=%0b, expected 0/0", note_on, note_change);
    end
    step(1);
    n_checks++;
    if (sel !== 3'd2 || note_on !== 1'b1 || note_change !== 1'b1) begin
      n_fail++;
      $display("FAIL single_lat: sel=%0d note_on=%0b chg=%0b, expected 2/1/1", sel, note_on, note_change);
    end
    step(1);
    n_checks++;
    if (note_change !== 1'b0) begin
      n_fail++;
      $display("FAIL single_width: chg=%0b in second cycle, expected 0", note_change);
    end
    keys_raw = 8'h00;
    sb.push_back('{sel: 3'd2, on: 1'b0});
    step(LAT + 3);
    n_checks++;
    if (sel !== 3'd2 || note_on !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: sel=%0d note_on=%0b, expected 2/0", sel, note_on);
    end
    drain("single");
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    pat = 8'b0011_0011;
    for (int i = 0; i < 8; i++) begin
      keys_raw = {4'b0, pat[i], 3'b0};
      step(1);
      n_checks++;
      if (note_on !== 1'b0 || note_change !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_quiet: cycle %0d note_on=%0b chg=%0b, expected 0/0", i, note_on, note_change);
      end
    end
    keys_raw = 8'h08;
    sb.push_back('{sel: 3'd3, on: 1'b1});
    step(LAT - 1);
    n_checks++;
    if (note_on !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_early: note_on=%0b before full count, expected 0", note_on);
    end
    step(1);
    n_checks++;
    if (sel !== 3'd3 || note_on !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_accept: sel=%0d note_on=%0b, expected 3/1", sel, note_on);
    end
    keys_raw = 8'h00;
    sb.push_back('{sel: 3'd3, on: 1'b0});
    step(LAT + 3);
    drain("bounce");
  endtask

  task automatic test_last_pressed();
    p0 = n_pulses;
    keys_raw = 8'h02;
    sb.push_back('{sel: 3'd1, on: 1'b1});
    step(LAT + 2);
    keys_raw = 8'h22;
    sb.push_back('{sel: 3'd5, on: 1'b1});
    step(LAT + 2);
    n_checks++;
    if (sel !== 3'd5 || note_on !== 1'b1) begin
      n_fail++;
      $display("FAIL last_press: sel=%0d note_on=%0b, expected 5/1", sel, note_on);
    end
    keys_raw = 8'h02;
    sb.push_back('{sel: 3'd1, on: 1'b1});
    step(LAT + 2);
    n_checks++;
    if (sel !== 3'd1 || note_on !== 1'b1) begin
      n_fail++;
      $display("FAIL last_fallback: sel=%0d note_on=%0b, expected 1/1", sel, note_on);
    end
    n_checks++;
    if (n_pulses - p0 !== 3) begin
      n_fail++;
      $display("FAIL last_pulses: %0d pulses, expected 3", n_pulses - p0);
    end
    keys_raw = 8'h00;
    sb.push_back('{sel: 3'd1, on: 1'b0});
    step(LAT + 3);
    drain("last");
  endtask

  task automatic test_simultaneous();
    keys_raw = 8'h44;
    sb.push_back('{sel: 3'd6, on: 1'b1});
    step(LAT + 2);
    n_checks++;
    if (sel !== 3'd6 || note_on !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_press: sel=%0d note_on=%0b, expected 6/1", sel, note_on);
    end
    keys_raw = 8'h00;
    sb.push_back('{sel: 3'd6, on: 1'b0});
    step(LAT + 2);
    n_checks++;
    if (sel !== 3'd6 || note_on !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_release: sel=%0d note_on=%0b, expected 6/0", sel, note_on);
    end
    drain("simul");
  endtask

  task automatic test_other_release_and_reset();
    keys_raw = 8'h11;
    sb.push_back('{sel: 3'd4, on: 1'b1});
    step(LAT + 2);
    p0 = n_pulses;
    keys_raw = 8'h10;
    step(LAT + 4);
    n_checks++;
    if (sel !== 3'd4 || note_on !== 1'b1 || n_pulses !== p0) begin
      n_fail++;
      $display("FAIL other_release: sel=%0d note_on=%0b pulses=%0d, expected 4/1/0", sel, note_on, n_pulses - p0);
    end
    keys_raw = 8'h90;
    step(4);
    reset_n = 1'b0;
    step(2);
    n_checks++;
    if ({sel, note_on, note_change} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_reset: sel=%0d note_on=%0b chg=%0b, expected 0/0/0", sel, note_on, note_change);
    end
    drain("mid_reset");
    reset_n = 1'b1;
    sb.push_back('{sel: 3'd7, on: 1'b1});
    step(LAT - 1);
    n_checks++;
    if (note_on !== 1'b0) begin
      n_fail++;
      $display("FAIL redebounce_early: note_on=%0b, expected 0", note_on);
    end
    step(1);
    n_checks++;
    if (sel !== 3'd7 || note_on !== 1'b1) begin
      n_fail++;
      $display("FAIL redebounce: sel=%0d note_on=%0b, expected 7/1", sel, note_on);
    end
    keys_raw = 8'h00;
    sb.push_back('{sel: 3'd7, on: 1'b0});
    step(LAT + 3);
    drain("redebounce");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_press();
    test_bounce();
    test_last_pressed();
    test_simultaneous();
    test_other_release_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
